// File: rtl/npc_pkg.sv
// Shared widths and the writeback request record used by the GPR writeback path.
package npc_pkg;

  localparam int XLEN   = 64;
  localparam int REG_AW = 5;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
    logic [XLEN-1:0]   pc;
  } wb_req_t;

endpackage

// File: rtl/gpr_wb_arbiter_rr_arb2.sv
// Two-input round-robin arbiter. The pointer names the requester that wins
// the next contended cycle; it moves only when something is actually granted.
module rr_arb2 (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic rr_ptr;

  // one-hot grant: a lone requester always wins, contention goes to rr_ptr
  always_comb begin
    grant = 2'b00;
    if (advance) begin
      if (valid == 2'b11) grant = rr_ptr ? 2'b10 : 2'b01;
      else                grant = valid;
    end
  end

  // after any grant, point at the requester that did not win
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)            rr_ptr <= 1'b0;
    else if (grant != 2'b00) rr_ptr <= grant[0];
  end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Shares the GPR write port between EXU (req0) and LSU (req1) writeback.
// A single registered output stage drives the register file write and the
// commit event; commit_hold freezes that stage while the reference model
// catches up.
module gpr_wb_arbiter
  import npc_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [REG_AW-1:0] req0_rd,
  input  logic [XLEN-1:0]   req0_data,
  input  logic [XLEN-1:0]   req0_pc,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [REG_AW-1:0] req1_rd,
  input  logic [XLEN-1:0]   req1_data,
  input  logic [XLEN-1:0]   req1_pc,
  input  logic              commit_hold,
  output logic              rf_wen,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              commit_valid,
  output logic [XLEN-1:0]   commit_pc,
  output logic [63:0]       retire_cnt
);

  logic       out_valid;
  wb_req_t    out_q;
  logic [63:0] retire_cnt_q;
  logic       fire;
  logic       advance;
  logic [1:0] grant;
  wb_req_t    req0_w;
  wb_req_t    req1_w;

  assign req0_w = '{rd: req0_rd, data: req0_data, pc: req0_pc};
  assign req1_w = '{rd: req1_rd, data: req1_data, pc: req1_pc};

  // a held, full stage blocks both retirement and new grants
  assign fire    = out_valid && !commit_hold;
  assign advance = !out_valid || !commit_hold;

  rr_arb2 u_rr_arb2 (
    .clock   (clock),
    .reset_n (reset_n),
    .valid   ({req1_valid, req0_valid}),
    .advance (advance),
    .grant   (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  // output stage: load the granted request whenever the stage may move
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_q     <= '0;
    end else if (advance) begin
      out_valid <= |grant;
      if (grant[0])      out_q <= req0_w;
      else if (grant[1]) out_q <= req1_w;
    end
  end

  // retired-instruction count, wraps naturally at 2^64
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  retire_cnt_q <= '0;
    else if (fire) retire_cnt_q <= retire_cnt_q + 64'd1;
  end

  // x0 writes still retire, they just never reach the register file
  assign rf_wen       = fire && (out_q.rd != REG_ZERO);
  assign rf_waddr     = out_q.rd;
  assign rf_wdata     = out_q.data;
  assign commit_valid = out_valid;
  assign commit_pc    = out_q.pc;
  assign retire_cnt   = retire_cnt_q;

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
module tb_gpr_wb_arbiter;
  import npc_pkg::*;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              req0_valid, req0_ready;
  logic [REG_AW-1:0] req0_rd;
  logic [XLEN-1:0]   req0_data, req0_pc;
  logic              req1_valid, req1_ready;
  logic [REG_AW-1:0] req1_rd;
  logic [XLEN-1:0]   req1_data, req1_pc;
  logic              commit_hold;
  logic              rf_wen;
  logic [REG_AW-1:0] rf_waddr;
  logic [XLEN-1:0]   rf_wdata;
  logic              commit_valid;
  logic [XLEN-1:0]   commit_pc;
  logic [63:0]       retire_cnt;

  gpr_wb_arbiter dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_rd      (req0_rd),
    .req0_data    (req0_data),
    .req0_pc      (req0_pc),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_rd      (req1_rd),
    .req1_data    (req1_data),
    .req1_pc      (req1_pc),
    .commit_hold  (commit_hold),
    .rf_wen       (rf_wen),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .commit_valid (commit_valid),
    .commit_pc    (commit_pc),
    .retire_cnt   (retire_cnt)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // behavioural model: one slot holding the next instruction to retire,
  // the requester that wins the next tie, and a retired count
  bit          m_valid = 0;
  logic [4:0]  m_rd = '0;
  logic [63:0] m_data = '0, m_pc = '0, m_cnt = '0;
  int          m_pref = 0;
  logic [63:0] m_rf [32];
  logic [63:0] d_rf [32];
  int          winner;
  bit          can_take;

  initial begin
    for (int r = 0; r < 32; r++) begin
      m_rf[r] = '0;
      d_rf[r] = '0;
    end
  end

  always @(negedge clock) begin
    if (!reset_n) begin
      m_valid = 0; m_pref = 0; m_cnt = '0; m_rd = '0; m_data = '0; m_pc = '0;
      chk("rst_rf_wen", rf_wen, 0);
      chk("rst_commit_valid", commit_valid, 0);
      chk("rst_retire_cnt", retire_cnt, 0);
    end else begin
      can_take = !m_valid || !commit_hold;
      winner = -1;
      if (can_take) begin
        if (req0_valid && req1_valid) winner = m_pref;
        else if (req0_valid)          winner = 0;
        else if (req1_valid)          winner = 1;
      end
      chk("m_req0_ready", req0_ready, winner == 0);
      chk("m_req1_ready", req1_ready, winner == 1);
      chk("m_commit_valid", commit_valid, m_valid);
      chk("m_rf_wen", rf_wen, m_valid && !commit_hold && m_rd != 5'd0);
      if (m_valid) begin
        chk("m_rf_waddr", rf_waddr, m_rd);
        chk("m_rf_wdata", rf_wdata, m_data);
        chk("m_commit_pc", commit_pc, m_pc);
      end
      chk("m_retire_cnt", retire_cnt, m_cnt);
      if (rf_wen) d_rf[rf_waddr] = rf_wdata;
      if (m_valid && !commit_hold) begin
        m_cnt = m_cnt + 64'd1;
        if (m_rd != 5'd0) m_rf[m_rd] = m_data;
      end
      if (can_take) begin
        m_valid = (winner >= 0);
        if (winner == 0) begin
          m_rd = req0_rd; m_data = req0_data; m_pc = req0_pc; m_pref = 1;
        end else if (winner == 1) begin
          m_rd = req1_rd; m_data = req1_data; m_pc = req1_pc; m_pref = 0;
        end
      end
    end
  end

  task automatic idle_inputs();
    req0_valid = 0; req0_rd = '0; req0_data = '0; req0_pc = '0;
    req1_valid = 0; req1_rd = '0; req1_data = '0; req1_pc = '0;
    commit_hold = 0;
  endtask

  int a_i, b_i;
  bit h0, h1;

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    chk("reset_rf_wen", rf_wen, 0);
    chk("reset_commit_valid", commit_valid, 0);
    chk("reset_rf_waddr", rf_waddr, 0);
    chk("reset_rf_wdata", rf_wdata, 0);
    chk("reset_commit_pc", commit_pc, 0);
    chk("reset_retire_cnt", retire_cnt, 0);

    // single EXU writeback
    @(posedge clock); #1;
    req0_valid = 1; req0_rd = 5'd5; req0_data = 64'h1234; req0_pc = 64'h8000_0000;
    @(negedge clock);
    chk("t1_req0_ready", req0_ready, 1);
    chk("t1_req1_ready", req1_ready, 0);
    @(posedge clock); #1;
    req0_valid = 0;
    @(negedge clock);
    chk("t1_rf_wen", rf_wen, 1);
    chk("t1_rf_waddr", rf_waddr, 5);
    chk("t1_rf_wdata", rf_wdata, 64'h1234);
    chk("t1_commit_pc", commit_pc, 64'h8000_0000);
    chk("t1_retire_pre", retire_cnt, 0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("t1_retire_cnt", retire_cnt, 1);
    chk("t1_commit_valid", commit_valid, 0);

    // LSU write to x0: commits, never writes
    @(posedge clock); #1;
    req1_valid = 1; req1_rd = 5'd0; req1_data = 64'hdead; req1_pc = 64'h8000_0004;
    @(negedge clock);
    chk("t3_req1_ready", req1_ready, 1);
    @(posedge clock); #1;
    req1_valid = 0;
    @(negedge clock);
    chk("t3_commit_valid", commit_valid, 1);
    chk("t3_rf_wen", rf_wen, 0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("t3_retire_cnt", retire_cnt, 2);

    // sustained contention alternates 0,1,0,1
    a_i = 0; b_i = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clock); #1;
      req0_valid = 1; req0_rd = 5'(10 + a_i); req0_data = 64'hA000 + 64'(a_i); req0_pc = 64'h8000_0100 + 64'(4 * a_i);
      req1_valid = 1; req1_rd = 5'(20 + b_i); req1_data = 64'hB000 + 64'(b_i); req1_pc = 64'h8000_0200 + 64'(4 * b_i);
      @(negedge clock);
      chk("t2_req0_ready", req0_ready, k % 2 == 0);
      chk("t2_req1_ready", req1_ready, k % 2 == 1);
      chk("t2_rf_wen", rf_wen, k > 0);
      if (k % 2 == 0) a_i++; else b_i++;
    end
    @(posedge clock); #1;
    req0_valid = 0; req1_valid = 0;
    @(negedge clock);
    chk("t2_rf_wen_last", rf_wen, 1);
    chk("t2_rf_waddr_last", rf_waddr, 21);
    @(posedge clock); #1;
    @(negedge clock);
    chk("t2_retire_cnt", retire_cnt, 6);
    chk("t2_rf_wen_idle", rf_wen, 0);

    // stage full then held for three cycles under contention
    @(posedge clock); #1;
    req0_valid = 1; req0_rd = 5'd7; req0_data = 64'hC0; req0_pc = 64'h8000_0300;
    @(negedge clock);
    chk("t4_fill_ready", req0_ready, 1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      commit_hold = 1;
      req0_valid = 1; req0_rd = 5'd8; req0_data = 64'hC1; req0_pc = 64'h8000_0304;
      req1_valid = 1; req1_rd = 5'd9; req1_data = 64'hD0; req1_pc = 64'h8000_0400;
      @(negedge clock);
      chk("t4_hold_ready0", req0_ready, 0);
      chk("t4_hold_ready1", req1_ready, 0);
      chk("t4_hold_wen", rf_wen, 0);
      chk("t4_hold_pc", commit_pc, 64'h8000_0300);
      chk("t4_hold_waddr", rf_waddr, 7);
    end
    @(posedge clock); #1;
    commit_hold = 0;
    @(negedge clock);
    chk("t4_rel_wen", rf_wen, 1);
    chk("t4_rel_waddr", rf_waddr, 7);
    chk("t4_rel_ready1", req1_ready, 1);
    chk("t4_rel_ready0", req0_ready, 0);
    @(posedge clock); #1;
    req1_valid = 0;
    @(negedge clock);
    chk("t4_next_ready0", req0_ready, 1);
    chk("t4_next_waddr", rf_waddr, 9);
    @(posedge clock); #1;
    req0_valid = 0;
    @(negedge clock);
    chk("t4_last_waddr", rf_waddr, 8);
    @(posedge clock); #1;
    @(negedge clock);
    chk("t4_retire_cnt", retire_cnt, 9);

    // counter wrap
    @(posedge clock); #2;
    force dut.retire_cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
    m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clock); #1;
    release dut.retire_cnt_q;
    req0_valid = 1; req0_rd = 5'd3; req0_data = 64'h33; req0_pc = 64'h8000_0500;
    @(negedge clock);
    chk("t5_retire_max", retire_cnt, 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge clock); #1;
    req0_valid = 0;
    @(posedge clock); #1;
    @(negedge clock);
    chk("t5_retire_wrap", retire_cnt, 0);

    // reset while the stage holds an entry
    @(posedge clock); #1;
    req0_valid = 1; req0_rd = 5'd12; req0_data = 64'hF0; req0_pc = 64'h8000_0600;
    @(posedge clock); #1;
    req0_valid = 0;
    @(negedge clock);
    chk("t6_pre_valid", commit_valid, 1);
    @(posedge clock); #3;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_wen", rf_wen, 0);
    chk("t6_rst_commit", commit_valid, 0);
    chk("t6_rst_retire", retire_cnt, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    req0_valid = 1; req0_rd = 5'd13; req0_data = 64'hE0; req0_pc = 64'h8000_0700;
    req1_valid = 1; req1_rd = 5'd14; req1_data = 64'hE1; req1_pc = 64'h8000_0704;
    @(negedge clock);
    chk("t6_post_ready0", req0_ready, 1);
    chk("t6_post_ready1", req1_ready, 0);
    h0 = req0_valid && req0_ready;
    h1 = req1_valid && req1_ready;

    // randomized traffic with legal hold/withdraw behaviour
    for (int i = 0; i < 3000; i++) begin
      @(posedge clock); #1;
      if (!req0_valid || h0) begin
        req0_valid = ($urandom % 3) != 0;
        req0_rd    = 5'($urandom_range(0, 31));
        req0_data  = {$urandom, $urandom};
        req0_pc    = {$urandom, $urandom};
      end else if ($urandom % 10 == 0) begin
        req0_valid = 0;
      end
      if (!req1_valid || h1) begin
        req1_valid = ($urandom % 3) != 0;
        req1_rd    = 5'($urandom_range(0, 31));
        req1_data  = {$urandom, $urandom};
        req1_pc    = {$urandom, $urandom};
      end else if ($urandom % 10 == 0) begin
        req1_valid = 0;
      end
      commit_hold = ($urandom % 4) == 0;
      @(negedge clock);
      h0 = req0_valid && req0_ready;
      h1 = req1_valid && req1_ready;
    end

    @(posedge clock); #1;
    idle_inputs();
    repeat (3) @(posedge clock);
    @(negedge clock);
    for (int r = 0; r < 32; r++) chk("regfile", d_rf[r], m_rf[r]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
